vector_deser_rev: RTL and testbench
===================================

// Module: vector_deser_rev
// PURPOSE
//   Serial-to-parallel deserializer that builds a WIDTH-bit vector one bit per cycle.
//   Incoming bits are placed LSB-first or MSB-first, so the block also undoes the
//   bit reversal applied by the upstream vector reversal/serializer path.
//   Double-buffered, so the serial input streams at 1 bit/cycle while the parallel
//   consumer applies backpressure on a valid/ready output.
// PARAMETERS
//   WIDTH   100   parallel word width in bits (>= 2)
//   CNT_W   $clog2(WIDTH)  localparam, bit-index counter width (derived, not overridable)
// PORTS
//   clk        in   1      single clock, all logic on rising edge
//   resetn     in   1      synchronous reset, active-low
//   msb_first  in   1      bit order: 0 = first bit -> [0], 1 = first bit -> [WIDTH-1]
//   s_valid    in   1      serial bit valid
//   s_bit      in   1      serial data bit
//   s_ready    out  1      block accepts s_bit this cycle (combinational)
//   m_valid    out  1      m_data holds a complete word
//   m_data     out  WIDTH  assembled parallel word
//   m_ready    in   1      consumer accepts m_data this cycle
//   busy       out  1      a partial word is in the assembly register
// BEHAVIOUR
//   Reset (resetn=0 at an edge): m_valid=0, m_data=0, busy=0, bit index=0, asm_full=0;
//     s_ready=1 on the first cycle after reset. Any partial or held word is discarded.
//   Bit accept = s_valid && s_ready. Bit k (k = 0..WIDTH-1) of a word is written to:
//     asm[k] when order_q=0, or asm[WIDTH-1-k] when order_q=1.
//   order_q: msb_first is latched when bit 0 is accepted.
//     - Bit 0 itself uses the live msb_first value.
//     - Changing msb_first mid-word has no effect until the next word.
//   Bit index increments per accepted bit. When bit WIDTH-1 is accepted:
//     index wraps to 0 and asm_full=1.
//   Transfer asm -> output register occurs when asm_full && (!m_valid || m_ready).
//     - On transfer: m_data <= asm, m_valid <= 1, asm_full <= 0.
//     - Latency: last bit accepted in cycle N -> m_valid=1 in cycle N+1
//       (if the output register is free).
//   s_ready = !asm_full || (!m_valid || m_ready).
//     - The assembly register may refill while the output register holds a word.
//     - Stall only when both registers are full and m_ready=0.
//   Accepting bit 0 of the next word in the same cycle as a transfer is legal.
//     Sustained throughput is 1 bit/cycle.
//   m_valid drops after m_valid && m_ready unless a transfer happens in the same cycle.
//   m_data is stable while m_valid && !m_ready.
//   busy = (index != 0) || asm_full.
//   s_bit is ignored when s_valid=0. No X propagates into m_data.
// STRUCTURE
//   Package vector_pkg:
//     typedef enum logic {LSB_FIRST=1'b0, MSB_FIRST=1'b1} bit_order_e;
//     function automatic int unsigned place_idx(int unsigned k, int unsigned w,
//                                               bit_order_e o);
//   Single module; no sub-module. Logic is the index counter, asm/asm_full,
//     output register and s_ready/transfer combinational logic.
//   The output stage is a 1-entry register slice, written inline.
// TESTING
//   1 Reset: hold resetn=0 for 2 cycles, release -> m_valid=0, m_data=0, busy=0, s_ready=1.
//   2 WIDTH=8, msb_first=0, bits 1,0,1,1,0,0,0,0 back-to-back, m_ready=1
//       -> m_data=8'h0D, m_valid=1 exactly one cycle after 8th bit, one cycle wide.
//   3 WIDTH=8, msb_first=1, same bits -> m_data=8'hB0.
//     Toggle msb_first after bit 3 -> still 8'hB0.
//   4 WIDTH=8, m_ready=0, stream 8'hA5 then 8'h3C LSB-first:
//       - s_ready=0 after the 16th bit; word 1 stays stable.
//       - Raise m_ready: 8'hA5, then 8'h3C the next cycle; s_ready=1 again.
//   5 WIDTH=8, 3 bits sent, resetn=0 for 1 cycle, then 8 bits 0xFF
//       -> m_data=8'hFF; no stale partial bits.
//   6 WIDTH=100, msb_first=1, s_bit = (k%3==0) for k = 0..99, s_valid gapped randomly
//       -> m_data[99-k] == (k%3==0) for all k; busy=0 after the transfer.

Source files
------------

// File: rtl/vector_pkg.sv
// Shared types and helpers for the vector reversal / deserializer path.
// place_idx maps the k-th serial bit of a w-bit word to its parallel position.
package vector_pkg;

  typedef enum logic {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } bit_order_e;

  function automatic int unsigned place_idx(int unsigned k, int unsigned w,
                                            bit_order_e o);
    return (o == MSB_FIRST) ? (w - 1 - k) : k;
  endfunction

endpackage

// File: rtl/vector_deser_rev.sv
// Serial-to-parallel deserializer, 1 bit/cycle, LSB- or MSB-first placement; word out 1 cycle after its last bit.
// Double-buffered: assembly refills while the output slice holds; s_ready drops only when both are full and m_ready=0.
module vector_deser_rev
  import vector_pkg::*;
#(
  parameter int unsigned WIDTH = 100
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             msb_first,
  input  logic             s_valid,
  input  logic             s_bit,
  output logic             s_ready,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [CNT_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] asm_q, asm_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             asm_full_q, asm_full_d;
  logic             valid_q, valid_d;
  bit_order_e       order_q, order_d;

  bit_order_e       cur_order;
  logic [CNT_W-1:0] pos;
  logic             out_free;
  logic             xfer;
  logic             accept;
  logic             last_bit;

  always_comb begin
    out_free  = !valid_q || m_ready;
    xfer      = asm_full_q && out_free;
    s_ready   = !asm_full_q || out_free;
    accept    = s_valid && s_ready;
    last_bit  = (idx_q == CNT_W'(WIDTH - 1));
    // Bit 0 follows the live pin; the rest of the word keeps the order latched with it.
    cur_order = (idx_q == '0) ? bit_order_e'(msb_first) : order_q;
    pos       = CNT_W'(place_idx(32'(idx_q), WIDTH, cur_order));

    idx_d      = idx_q;
    asm_d      = asm_q;
    asm_full_d = asm_full_q;
    order_d    = order_q;
    data_d     = data_q;
    valid_d    = valid_q;

    if (xfer) begin
      data_d     = asm_q;
      asm_full_d = 1'b0;
    end

    // A transfer and the last bit of a word never coincide: while asm is full
    // the index sits at 0, so any bit accepted alongside a transfer is bit 0.
    if (accept) begin
      asm_d[pos] = s_bit;
      order_d    = cur_order;
      if (last_bit) begin
        idx_d      = '0;
        asm_full_d = 1'b1;
      end else begin
        idx_d = idx_q + CNT_W'(1);
      end
    end

    if (xfer) begin
      valid_d = 1'b1;
    end else if (m_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      idx_q      <= '0;
      asm_q      <= '0;
      asm_full_q <= 1'b0;
      order_q    <= LSB_FIRST;
      data_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      asm_q      <= asm_d;
      asm_full_q <= asm_full_d;
      order_q    <= order_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
    end
  end

  assign m_valid = valid_q;
  assign m_data  = data_q;
  assign busy    = (idx_q != '0) || asm_full_q;

endmodule

// File: tb/tb_vector_deser_rev.sv
// Bench for vector_deser_rev: an 8-bit and a 100-bit instance, table-driven vectors plus
// directed stall/reset/gapped sequences, words checked against a scoreboard queue.
module tb_vector_deser_rev;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic       msb8, s8v, s8b, sr8, mv8, mr8, busy8;
  logic [7:0] md8;
  logic       msb100, s100v, s100b, sr100, mv100, mr100, busy100;
  logic [99:0] md100;

  int checks = 0;
  int failures = 0;

  logic [7:0]  q8[$];
  logic [99:0] q100[$];

  vector_deser_rev #(.WIDTH(8)) u8 (
    .clk(clk), .resetn(resetn), .msb_first(msb8), .s_valid(s8v), .s_bit(s8b),
    .s_ready(sr8), .m_valid(mv8), .m_data(md8), .m_ready(mr8), .busy(busy8)
  );

  vector_deser_rev #(.WIDTH(100)) u100 (
    .clk(clk), .resetn(resetn), .msb_first(msb100), .s_valid(s100v), .s_bit(s100b),
    .s_ready(sr100), .m_valid(mv100), .m_data(md100), .m_ready(mr100), .busy(busy100)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk100(input string name, input logic [99:0] act, input logic [99:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Scoreboard: compare every word the consumer takes against the queue head.
  always @(negedge clk) begin
    if (resetn === 1'b1 && mv8 === 1'b1 && mr8 === 1'b1) begin
      if (q8.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL w8_unexpected actual=%h required=none", md8);
      end else begin
        chk8("w8_word", md8, q8.pop_front());
      end
    end
    if (resetn === 1'b1 && mv100 === 1'b1 && mr100 === 1'b1) begin
      if (q100.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL w100_unexpected actual=%h required=none", md100);
      end else begin
        chk100("w100_word", md100, q100.pop_front());
      end
    end
  end

  // Present one bit; returns one step after the edge that accepted it.
  task automatic send8(input logic b);
    int n;
    n = 0;
    s8v = 1'b1;
    s8b = b;
    @(negedge clk);
    while (sr8 !== 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (sr8 !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL send8_timeout actual=s_ready_%b required=1", sr8);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send100(input logic b);
    int n;
    n = 0;
    s100v = 1'b1;
    s100b = b;
    @(negedge clk);
    while (sr100 !== 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (sr100 !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL send100_timeout actual=s_ready_%b required=1", sr100);
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] stream;  // stream[k] is the k-th serial bit
    logic       msb;
    logic       tog;     // flip msb_first after bit 3
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  w1, w2;
    logic [99:0] exp100;

    tbl[0] = '{8'h0D, 1'b0, 1'b0, 8'h0D};
    tbl[1] = '{8'h0D, 1'b1, 1'b0, 8'hB0};
    tbl[2] = '{8'h0D, 1'b1, 1'b1, 8'hB0};
    tbl[3] = '{8'hF0, 1'b0, 1'b1, 8'hF0};
    tbl[4] = '{8'h01, 1'b1, 1'b0, 8'h80};
    tbl[5] = '{8'hC1, 1'b1, 1'b0, 8'h83};

    resetn = 1'b0;
    msb8 = 1'b0; s8v = 1'b0; s8b = 1'b0; mr8 = 1'b1;
    msb100 = 1'b0; s100v = 1'b0; s100b = 1'b0; mr100 = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk1("rst_mvalid8", mv8, 1'b0);
    chk8("rst_mdata8", md8, 8'h00);
    chk1("rst_busy8", busy8, 1'b0);
    chk1("rst_sready8", sr8, 1'b1);
    chk1("rst_mvalid100", mv100, 1'b0);
    chk100("rst_mdata100", md100, '0);
    chk1("rst_busy100", busy100, 1'b0);
    chk1("rst_sready100", sr100, 1'b1);
    @(posedge clk);
    #1;

    // Table: order, mid-word msb_first toggling, output latency and pulse width
    for (int i = 0; i < 6; i++) begin
      msb8 = tbl[i].msb;
      q8.push_back(tbl[i].exp);
      for (int k = 0; k < 8; k++) begin
        send8(tbl[i].stream[k]);
        if (k == 3 && tbl[i].tog) msb8 = ~tbl[i].msb;
      end
      s8v = 1'b0;
      @(negedge clk);
      chk1("lat_early", mv8, 1'b0);
      chk1("busy_full", busy8, 1'b1);
      @(negedge clk);
      chk1("lat_valid", mv8, 1'b1);
      @(negedge clk);
      chk1("one_cycle", mv8, 1'b0);
      @(posedge clk);
      #1;
    end

    // Both registers full under backpressure, then drain
    w1 = 8'hA5;
    w2 = 8'h3C;
    mr8 = 1'b0;
    msb8 = 1'b0;
    q8.push_back(w1);
    q8.push_back(w2);
    for (int k = 0; k < 8; k++) send8(w1[k]);
    for (int k = 0; k < 8; k++) send8(w2[k]);
    s8v = 1'b0;
    @(negedge clk);
    chk1("stall_sready", sr8, 1'b0);
    chk1("stall_mvalid", mv8, 1'b1);
    chk8("stall_word1", md8, 8'hA5);
    repeat (3) @(negedge clk);
    chk8("stall_stable", md8, 8'hA5);
    chk1("stall_sready_hold", sr8, 1'b0);
    @(posedge clk);
    #1 mr8 = 1'b1;
    #1 chk1("drain_sready", sr8, 1'b1);
    @(negedge clk);
    chk8("drain_first", md8, 8'hA5);
    @(negedge clk);
    chk8("drain_second", md8, 8'h3C);
    chk1("drain_second_vld", mv8, 1'b1);
    @(negedge clk);
    chk1("drain_done", mv8, 1'b0);
    @(posedge clk);
    #1;

    // Partial word discarded by reset
    send8(1'b1);
    send8(1'b1);
    send8(1'b0);
    s8v = 1'b0;
    chk1("partial_busy", busy8, 1'b1);
    resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk1("mid_rst_busy", busy8, 1'b0);
    chk8("mid_rst_mdata", md8, 8'h00);
    chk1("mid_rst_mvalid", mv8, 1'b0);
    @(posedge clk);
    #1;
    msb8 = 1'b0;
    q8.push_back(8'hFF);
    for (int k = 0; k < 8; k++) send8(1'b1);
    s8v = 1'b0;
    for (int i = 0; i < 20 && q8.size() != 0; i++) @(negedge clk);
    chk_int("ff_drained", q8.size(), 0);

    // WIDTH=100, MSB-first, randomly gapped valid, msb_first flipped mid-word
    @(posedge clk);
    #1;
    msb100 = 1'b1;
    exp100 = '0;
    for (int k = 0; k < 100; k++) exp100[99-k] = (k % 3 == 0);
    q100.push_back(exp100);
    for (int k = 0; k < 100; k++) begin
      int gap;
      gap = int'($urandom_range(2, 0));
      s100v = 1'b0;
      repeat (gap) begin
        s100b = 1'($urandom);
        @(posedge clk);
        #1;
      end
      if (k == 50) msb100 = 1'b0;
      send100(k % 3 == 0);
    end
    s100v = 1'b0;
    for (int i = 0; i < 20 && q100.size() != 0; i++) @(negedge clk);
    chk_int("w100_drained", q100.size(), 0);
    chk1("w100_busy_after", busy100, 1'b0);

    repeat (3) @(negedge clk);
    chk_int("q8_empty", q8.size(), 0);
    chk1("end_mvalid8", mv8, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
